shared_reg_arbiter: RTL

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// Shared WIDTH-bit load register fed by four requesters through a round-robin arbiter.
// Optional grant hold (lock port + 2-bit hold counter) enabled by defining SHARED_REG_LOCK_EN.
module shared_reg_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
`ifdef SHARED_REG_LOCK_EN
    input  logic [3:0]       lock,
`endif
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       gnt,
    output logic             ld,
    output logic [WIDTH-1:0] q
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned PW   = 2;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic [PW-1:0]    idx;
    logic             found;
    logic [WIDTH-1:0] sel;

`ifdef SHARED_REG_LOCK_EN
    logic [PW-1:0]    hold_cnt;
    logic [PW-1:0]    hold_cnt_nxt;
`endif

    // Round-robin search starting at ptr; a locked grant may override it.
    always_comb begin
        gnt_nxt = '0;
        ptr_nxt = ptr;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr + PW'(k);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt_nxt[idx] = 1'b1;
                ptr_nxt      = idx + PW'(1);
            end
        end
`ifdef SHARED_REG_LOCK_EN
        hold_cnt_nxt = '0;
        // Hold the current grant at most four consecutive cycles, ptr frozen meanwhile.
        if ((|(gnt & req & lock)) && (hold_cnt != PW'(3))) begin
            gnt_nxt      = gnt;
            ptr_nxt      = ptr;
            hold_cnt_nxt = hold_cnt + PW'(1);
        end
`endif
    end

    // Register input mux driven by the one-hot grant.
    always_comb begin
        sel = '0;
        if (gnt[0]) sel = din0;
        if (gnt[1]) sel = din1;
        if (gnt[2]) sel = din2;
        if (gnt[3]) sel = din3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt <= '0;
            ld  <= 1'b0;
            q   <= '0;
            ptr <= '0;
`ifdef SHARED_REG_LOCK_EN
            hold_cnt <= '0;
`endif
        end else begin
            gnt <= gnt_nxt;
            ld  <= |gnt_nxt;
            ptr <= ptr_nxt;
            if (|gnt) q <= sel;
`ifdef SHARED_REG_LOCK_EN
            hold_cnt <= hold_cnt_nxt;
`endif
        end
    end

endmodule
